// File: rtl/fetch_ctrl.sv
// Instruction-fetch sequencer: holds the PC, drives a single-cycle instruction
// memory and registers fetched words into the IF/ID register for decode.
//
// Handshake toward decode: instr/pc_out are offered while instr_valid is high;
// a transfer (accept) happens on a rising edge where instr_valid && dec_ready.
// While instr_valid is high and dec_ready is low, instr and pc_out hold.
// Redirect inputs (jump/branch_taken and their operands) count only on accept.
module fetch_ctrl #(
    parameter int                ADDR_W    = 6,
    parameter int                DATA_W    = 32,
    parameter int                LAST_ADDR = 55,
    parameter int                RESET_PC  = 0,
    parameter logic [DATA_W-1:0] HALT_WORD = 32'hFFFF_FFFF
) (
    input  logic              reloj,
    input  logic              reset,
    input  logic              start,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic [DATA_W-1:0] imem_data,
    output logic [DATA_W-1:0] instr,
    output logic              instr_valid,
    input  logic              dec_ready,
    output logic [ADDR_W-1:0] pc_out,
    output logic [ADDR_W-1:0] pc_plus1,
    input  logic              branch_taken,
    input  logic [15:0]       branch_off,
    input  logic              jump,
    input  logic [ADDR_W-1:0] jump_target,
    output logic              halted,
    output logic              err,
    output logic [2:0]        dbg_state
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_RUN  = 3'd1,
        S_END  = 3'd2,
        S_HALT = 3'd3,
        S_ERR  = 3'd4
    } state_t;

    localparam logic [ADDR_W-1:0] LAST  = ADDR_W'(LAST_ADDR);
    localparam logic [ADDR_W-1:0] START = ADDR_W'(RESET_PC);

    state_t            state, state_nxt;
    logic [ADDR_W-1:0] pc, pc_nxt;
    logic [DATA_W-1:0] instr_nxt;
    logic              valid_nxt;
    logic [ADDR_W-1:0] pcout_nxt;

    logic              accept;
    logic              redir;
    logic              fire;
    logic [17:0]       br_target;
    logic              br_ok;
    logic              tgt_ok;
    logic [ADDR_W-1:0] tgt_addr;

    // Handshake and redirect-target arithmetic. The branch target is formed
    // in 18 bits so that negative or far targets are seen as out of range
    // rather than wrapping into the program.
    always_comb begin
        accept    = instr_valid && dec_ready;
        redir     = accept && (jump || branch_taken);
        fire      = !instr_valid || dec_ready;
        br_target = {{(18-ADDR_W){1'b0}}, pc_out} + 18'd1
                  + {{2{branch_off[15]}}, branch_off};
        br_ok     = !br_target[17] && (br_target <= 18'(LAST_ADDR));
        tgt_addr  = jump ? jump_target : br_target[ADDR_W-1:0];
        tgt_ok    = jump ? (jump_target <= LAST) : br_ok;
    end

    // State register.
    always_ff @(posedge reloj or negedge reset) begin
        if (!reset) state <= S_IDLE;
        else        state <= state_nxt;
    end

    // Next state and next datapath values.
    always_comb begin
        state_nxt = state;
        pc_nxt    = pc;
        instr_nxt = instr;
        valid_nxt = instr_valid;
        pcout_nxt = pc_out;
        if ((state == S_RUN || state == S_END) && redir) begin
            // The word read at the old pc this cycle is dropped: one bubble.
            valid_nxt = 1'b0;
            if (tgt_ok) begin
                pc_nxt    = tgt_addr;
                state_nxt = S_RUN;
            end else begin
                state_nxt = S_ERR;
            end
        end else begin
            case (state)
                S_IDLE, S_HALT, S_ERR: begin
                    valid_nxt = 1'b0;
                    if (start) begin
                        pc_nxt    = START;
                        state_nxt = S_RUN;
                    end
                end
                S_RUN: begin
                    if (fire) begin
                        if (imem_data == HALT_WORD) begin
                            valid_nxt = 1'b0;
                            state_nxt = S_HALT;
                        end else begin
                            instr_nxt = imem_data;
                            pcout_nxt = pc;
                            valid_nxt = 1'b1;
                            if (pc == LAST) state_nxt = S_END;
                            else            pc_nxt    = pc + 1'b1;
                        end
                    end
                end
                S_END: begin
                    // Accepting the last word without a redirect falls off the program.
                    if (accept) begin
                        valid_nxt = 1'b0;
                        state_nxt = S_ERR;
                    end
                end
                default: begin
                    valid_nxt = 1'b0;
                    state_nxt = S_IDLE;
                end
            endcase
        end
    end

    // PC and IF/ID register.
    always_ff @(posedge reloj or negedge reset) begin
        if (!reset) begin
            pc          <= START;
            instr       <= '0;
            instr_valid <= 1'b0;
            pc_out      <= '0;
        end else begin
            pc          <= pc_nxt;
            instr       <= instr_nxt;
            instr_valid <= valid_nxt;
            pc_out      <= pcout_nxt;
        end
    end

    // Outputs decoded from the registered state and PC.
    always_comb begin
        imem_addr = pc;
        pc_plus1  = pc_out + 1'b1;
        halted    = (state == S_HALT);
        err       = (state == S_ERR);
        dbg_state = state;
    end

endmodule
